position_read_sequencer: RTL and testbench

- Responder to the position-read controller's dispatch/done protocol: accepts batch dispatch commands and issues one cell-memory read per cycle for each particle in the current cell.
- Tracks outstanding returns and tags each returned position with its particle index.
- Reports `finished_batch`, `finished_all` and `in_flight` back to the controller.
- Sits between the position-read controller and the cell position BRAM, feeding the force pipeline.

---
 rtl/position_read_sequencer.sv | 148 ++++++++++++++
 tb/tb_position_read_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/position_read_sequencer.sv
// Position-read sequencer: turns dispatch commands into bursts of cell-memory reads
// and forwards in-order memory returns tagged with their particle index.
module position_read_sequencer #(
  parameter int IDX_W  = 6,
  parameter int DATA_W = 96,
  parameter int BATCH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_dispatch,
  input  logic              i_done,
  input  logic [IDX_W:0]    i_cell_count,
  output logic              o_rd_en,
  output logic [IDX_W-1:0]  o_rd_addr,
  input  logic              i_rd_valid,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_pos_valid,
  output logic [DATA_W-1:0] o_pos_data,
  output logic [IDX_W-1:0]  o_pos_index,
  output logic              o_finished_batch,
  output logic              o_finished_all,
  output logic              o_in_flight,
  output logic              o_err_spurious
);

  localparam int OW = $clog2(BATCH + 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t            r_state, w_state_next;
  logic [IDX_W:0]    r_ptr, r_count_q;
  logic [IDX_W-1:0]  r_ret_ptr;
  logic [OW-1:0]     r_outstanding, r_burst;
  logic              r_drop, r_batch_pend;
  logic              r_rd_en, r_pos_valid, r_fin_batch, r_fin_all, r_err;
  logic [IDX_W-1:0]  r_rd_addr, r_pos_index;
  logic [DATA_W-1:0] r_pos_data;

  logic              w_rewind, w_accept, w_issue, w_ret, w_fwd;
  logic [IDX_W:0]    w_remain;
  logic [OW-1:0]     w_burst_init, w_out_next;

  assign w_rewind = (i_dispatch == 2'b11);
  assign w_accept = !w_rewind && (i_dispatch == 2'b01) && (r_state == S_IDLE) &&
                    (r_outstanding == '0) && !i_done && (r_ptr < r_count_q);
  // A rewind arriving during ISSUE suppresses the read that would have gone out.
  assign w_issue  = !w_rewind && (r_state == S_ISSUE);
  assign w_ret    = i_rd_valid && (r_outstanding != '0);
  assign w_fwd    = w_ret && !r_drop;

  assign w_remain     = r_count_q - r_ptr;
  assign w_burst_init = (w_remain > (IDX_W+1)'(BATCH)) ? OW'(BATCH) : OW'(w_remain);

  always_comb begin
    w_out_next = r_outstanding;
    if (w_issue && !w_ret)      w_out_next = r_outstanding + OW'(1);
    else if (!w_issue && w_ret) w_out_next = r_outstanding - OW'(1);
  end

  always_comb begin
    w_state_next = r_state;
    if (w_rewind) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
        S_ISSUE: if (r_burst == OW'(1)) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr         <= '0;
      r_ret_ptr     <= '0;
      r_count_q     <= '0;
      r_outstanding <= '0;
      r_burst       <= '0;
      r_drop        <= 1'b0;
      r_batch_pend  <= 1'b0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_pos_valid   <= 1'b0;
      r_pos_data    <= '0;
      r_pos_index   <= '0;
      r_fin_batch   <= 1'b0;
      r_fin_all     <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      r_pos_valid   <= w_fwd;
      if (w_fwd) begin
        r_pos_data  <= i_rd_data;
        r_pos_index <= r_ret_ptr;
        r_ret_ptr   <= r_ret_ptr + IDX_W'(1);
      end
      if (i_rd_valid && (r_outstanding == '0)) r_err <= 1'b1;

      // Drop mode persists only while aborted reads are still coming back.
      if (w_rewind)               r_drop <= (w_out_next != '0);
      else if (w_out_next == '0)  r_drop <= 1'b0;

      if (w_rewind) begin
        r_count_q    <= i_cell_count;
        r_ptr        <= '0;
        r_ret_ptr    <= '0;
        r_burst      <= '0;
        r_rd_en      <= 1'b0;
        r_batch_pend <= 1'b0;
        r_fin_all    <= (i_cell_count == '0);
        r_fin_batch  <= (i_cell_count == '0);
      end else begin
        r_rd_en <= w_issue;
        if (w_accept) begin
          r_burst      <= w_burst_init;
          r_fin_batch  <= 1'b0;
          r_batch_pend <= 1'b1;
        end else if (r_batch_pend && (r_state == S_IDLE) && (r_outstanding == '0)) begin
          r_fin_batch  <= 1'b1;
          r_batch_pend <= 1'b0;
        end
        if (w_issue) begin
          r_rd_addr <= r_ptr[IDX_W-1:0];
          r_ptr     <= r_ptr + (IDX_W+1)'(1);
          r_burst   <= r_burst - OW'(1);
          if (r_ptr + (IDX_W+1)'(1) == r_count_q) r_fin_all <= 1'b1;
        end
      end
    end
  end

  assign o_rd_en          = r_rd_en;
  assign o_rd_addr        = r_rd_addr;
  assign o_pos_valid      = r_pos_valid;
  assign o_pos_data       = r_pos_data;
  assign o_pos_index      = r_pos_index;
  assign o_finished_batch = r_fin_batch;
  assign o_finished_all   = r_fin_all;
  assign o_in_flight      = (r_state == S_ISSUE) || (r_outstanding != '0);
  assign o_err_spurious   = r_err;

endmodule

// File: tb/tb_position_read_sequencer.sv
// Bench for position_read_sequencer: in-order memory model with variable latency and a
// transaction-level reference (expected address runs, index tags, data, status flags).
module tb_position_read_sequencer;
  localparam int IDX_W  = 6;
  localparam int DATA_W = 96;
  localparam int BATCH  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        dispatch;
  logic              done;
  logic [IDX_W:0]    cell_count;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              pos_valid;
  logic [DATA_W-1:0] pos_data;
  logic [IDX_W-1:0]  pos_index;
  logic              fin_batch, fin_all, in_flight, err_spurious;

  position_read_sequencer #(.IDX_W(IDX_W), .DATA_W(DATA_W), .BATCH(BATCH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dispatch(dispatch), .i_done(done),
    .i_cell_count(cell_count), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
    .i_rd_valid(rd_valid), .i_rd_data(rd_data), .o_pos_valid(pos_valid),
    .o_pos_data(pos_data), .o_pos_index(pos_index), .o_finished_batch(fin_batch),
    .o_finished_all(fin_all), .o_in_flight(in_flight), .o_err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int due; int addr; } req_t;
  logic [DATA_W-1:0] mem [64];
  req_t              pend_q[$];
  int                rd_cyc[$];
  int                rd_adr[$];
  bit                rd_fa[$];
  int                pos_cyc[$];
  int                pos_idx[$];
  logic [DATA_W-1:0] pos_dat[$];
  int                cyc = 0;
  int                lat = 3;
  bit                inj_spur = 0;
  int                fb_rise = -1;
  bit                fb_prev = 0;
  int                ptr_m = 0;
  int                cnt_m = 0;

  // Memory responder and bus monitor share one process so the cycle count is coherent.
  always @(negedge clk) begin
    req_t r;
    cyc++;
    if (rst_n && rd_en) begin
      rd_cyc.push_back(cyc);
      rd_adr.push_back(int'(rd_addr));
      rd_fa.push_back(fin_all);
      pend_q.push_back('{cyc + lat, int'(rd_addr)});
    end
    if (pos_valid) begin
      pos_cyc.push_back(cyc);
      pos_idx.push_back(int'(pos_index));
      pos_dat.push_back(pos_data);
    end
    if (fin_batch && !fb_prev && fb_rise < 0) fb_rise = cyc;
    fb_prev  = fin_batch;
    rd_valid = 1'b0;
    rd_data  = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      r = pend_q.pop_front();
      rd_valid = 1'b1;
      rd_data  = mem[r.addr];
    end else if (inj_spur) begin
      rd_valid = 1'b1;
      rd_data  = {$urandom(), $urandom(), $urandom()};
      inj_spur = 0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); rd_adr.delete(); rd_fa.delete();
    pos_cyc.delete(); pos_idx.delete(); pos_dat.delete();
    fb_rise = -1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic rewind(input int cnt);
    cell_count = (IDX_W+1)'(cnt);
    dispatch   = 2'b11;
    tick();
    dispatch   = 2'b00;
    ptr_m = 0;
    cnt_m = cnt;
  endtask

  // One accepted dispatch: expect a contiguous, bubble-free run of min(BATCH, remaining)
  // reads, in-order tagged returns, and finished_batch one cycle after the last position.
  task automatic run_batch(input int hold, input string tag);
    int exp_n, t, n;
    exp_n = (cnt_m - ptr_m > BATCH) ? BATCH : cnt_m - ptr_m;
    clear_logs();
    dispatch = 2'b01;
    tick(hold);
    dispatch = 2'b00;
    t = 0;
    while (!(!in_flight && fin_batch) && t < 300) begin
      tick();
      t++;
    end
    chk({tag, "_complete"}, 128'(t < 300), 128'(1));
    chk({tag, "_nreads"}, 128'(rd_adr.size()), 128'(exp_n));
    chk({tag, "_npos"}, 128'(pos_idx.size()), 128'(exp_n));
    n = (rd_adr.size() < exp_n) ? rd_adr.size() : exp_n;
    for (int k = 0; k < n; k++) begin
      chk({tag, "_addr"}, 128'(rd_adr[k]), 128'(ptr_m + k));
      chk({tag, "_fin_all_at_read"}, 128'(rd_fa[k]), 128'(ptr_m + k == cnt_m - 1));
      if (k > 0) chk({tag, "_no_bubble"}, 128'(rd_cyc[k] - rd_cyc[k-1]), 128'(1));
    end
    n = (pos_idx.size() < exp_n) ? pos_idx.size() : exp_n;
    for (int k = 0; k < n; k++) begin
      chk({tag, "_pos_index"}, 128'(pos_idx[k]), 128'(ptr_m + k));
      chk({tag, "_pos_data"}, 128'(pos_dat[k]), 128'(mem[ptr_m + k]));
    end
    if (n > 0) chk({tag, "_fb_timing"}, 128'(fb_rise), 128'(pos_cyc[n-1] + 1));
    ptr_m += exp_n;
    chk({tag, "_fin_all"}, 128'(fin_all), 128'(ptr_m == cnt_m));
    $display("batch %s: reads=%0d positions=%0d ptr=%0d/%0d lat=%0d",
             tag, rd_adr.size(), pos_idx.size(), ptr_m, cnt_m, lat);
  endtask

  task automatic no_accept(input int hold, input bit done_v, input string tag);
    clear_logs();
    done     = done_v;
    dispatch = 2'b01;
    tick(hold);
    dispatch = 2'b00;
    done     = 1'b0;
    tick(15);
    chk({tag, "_no_reads"}, 128'(rd_adr.size()), 128'(0));
    chk({tag, "_no_pos"}, 128'(pos_idx.size()), 128'(0));
    $display("ignored dispatch %s: reads=%0d", tag, rd_adr.size());
  endtask

  initial begin
    int t;
    rst_n = 1'b0; dispatch = 2'b00; done = 1'b0; cell_count = '0;
    rd_valid = 1'b0; rd_data = '0;
    fill_mem();
    tick(3);
    chk("rst_rd_en", 128'(rd_en), 128'(0));
    chk("rst_rd_addr", 128'(rd_addr), 128'(0));
    chk("rst_pos_valid", 128'(pos_valid), 128'(0));
    chk("rst_pos_data", 128'(pos_data), 128'(0));
    chk("rst_pos_index", 128'(pos_index), 128'(0));
    chk("rst_fin_batch", 128'(fin_batch), 128'(0));
    chk("rst_fin_all", 128'(fin_all), 128'(0));
    chk("rst_in_flight", 128'(in_flight), 128'(0));
    chk("rst_err", 128'(err_spurious), 128'(0));
    rst_n = 1'b1;
    tick(2);

    lat = 3;
    rewind(20);
    chk("rw20_fin_all", 128'(fin_all), 128'(0));
    chk("rw20_fin_batch", 128'(fin_batch), 128'(0));
    run_batch(10, "b0_held");
    run_batch(1, "b1");
    run_batch(1, "b2_tail");
    chk("cell_fin_batch", 128'(fin_batch), 128'(1));
    no_accept(3, 1'b0, "exhausted");

    for (int it = 0; it < 5; it++) begin
      lat = $urandom_range(1, 6);
      fill_mem();
      rewind($urandom_range(1, 40));
      if (it % 2 == 1) no_accept(2, 1'b1, "done_high");
      while (ptr_m < cnt_m) run_batch($urandom_range(1, 3), $sformatf("rnd%0d", it));
      chk("rnd_fin_all", 128'(fin_all), 128'(1));
    end

    rewind(0);
    chk("empty_fin_batch", 128'(fin_batch), 128'(1));
    chk("empty_fin_all", 128'(fin_all), 128'(1));
    no_accept(2, 1'b0, "empty");

    lat = 4;
    fill_mem();
    rewind(20);
    clear_logs();
    dispatch = 2'b01;
    tick();
    dispatch = 2'b00;
    t = 0;
    while (rd_adr.size() < 2 && t < 20) begin
      tick();
      t++;
    end
    chk("abort_started", 128'(t < 20), 128'(1));
    dispatch = 2'b11;
    tick();
    dispatch = 2'b00;
    ptr_m = 0;
    tick(20);
    chk("abort_rd_en", 128'(rd_en), 128'(0));
    chk("abort_short", 128'(rd_adr.size() < BATCH), 128'(1));
    chk("abort_no_pos", 128'(pos_idx.size()), 128'(0));
    chk("abort_in_flight", 128'(in_flight), 128'(0));
    chk("abort_err", 128'(err_spurious), 128'(0));
    $display("abort: reads before rewind=%0d positions=%0d", rd_adr.size(), pos_idx.size());
    run_batch(1, "restart");

    clear_logs();
    inj_spur = 1;
    tick(3);
    chk("spur_err", 128'(err_spurious), 128'(1));
    chk("spur_no_pos", 128'(pos_idx.size()), 128'(0));
    tick(5);
    chk("spur_err_sticky", 128'(err_spurious), 128'(1));
    $display("spurious return: err=%0b", err_spurious);
    run_batch(1, "after_spur");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
